// File: rtl/cache_sram_array.sv
// ---------------------------------------------------------------------------
// cache_sram_array
//
// Single-port (1RW) synchronous SRAM model used for L1 cache tag and data
// arrays. It builds on the plain array model with three additions:
//   - per-group write masking (WMASK_WIDTH groups of DATA_WIDTH/WMASK_WIDTH bits)
//   - an init sequencer that writes INIT_VALUE to every entry after reset
//   - a flush sequencer, started by flush0, that does the same at run time
//
// Parameters
//   DATA_WIDTH   bits per word, a multiple of WMASK_WIDTH
//   ADDR_WIDTH   address bits, DEPTH = 1 << ADDR_WIDTH
//   WMASK_WIDTH  number of write-mask groups
//   INIT_VALUE   word written to every entry by init and flush
//
// Ports
//   clk0    in   clock, all state changes on posedge
//   rst_n   in   asynchronous active-low reset
//   csb0    in   active-low chip select
//   web0    in   active-low write enable
//   wmask0  in   per-group write enable, bit g covers din0[(g+1)*G-1 : g*G]
//   addr0   in   word address
//   din0    in   write data
//   flush0  in   flush request, honoured only while the array is idle
//   dout0   out  registered read data, holds when no read is performed
//   ready0  out  high while the array accepts accesses
// ---------------------------------------------------------------------------
module cache_sram_array #(
    parameter int                    DATA_WIDTH  = 24,
    parameter int                    ADDR_WIDTH  = 4,
    parameter int                    WMASK_WIDTH = 3,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = '0
) (
    input  logic                   clk0,
    input  logic                   rst_n,
    input  logic                   csb0,
    input  logic                   web0,
    input  logic [WMASK_WIDTH-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0]  addr0,
    input  logic [DATA_WIDTH-1:0]  din0,
    input  logic                   flush0,
    output logic [DATA_WIDTH-1:0]  dout0,
    output logic                   ready0
);

    localparam int                    DEPTH    = 1 << ADDR_WIDTH;
    localparam int                    GROUP_W  = DATA_WIDTH / WMASK_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = '1;

    // A width that does not split evenly into mask groups would leave the
    // top bits permanently unwritable, so refuse to elaborate it.
    if ((DATA_WIDTH % WMASK_WIDTH) != 0) begin : g_bad_width
        $error("cache_sram_array: DATA_WIDTH must be a multiple of WMASK_WIDTH");
    end

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   ptr;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    seq_p0;
    logic                    rd_p0;
    logic                    wr_p0;

    // Replace only the groups whose mask bit is set; the rest keep old data.
    function automatic logic [DATA_WIDTH-1:0] merge_word(
        input logic [DATA_WIDTH-1:0]  old_word,
        input logic [DATA_WIDTH-1:0]  new_word,
        input logic [WMASK_WIDTH-1:0] mask
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int g = 0; g < WMASK_WIDTH; g++) begin
            if (mask[g]) begin
                res[g*GROUP_W +: GROUP_W] = new_word[g*GROUP_W +: GROUP_W];
            end
        end
        return res;
    endfunction

    // ---- stage p0: access decode ------------------------------------------
    // While a sequencer owns the array every external request is dropped,
    // which is what keeps csb0/web0/flush0 inert outside IDLE.
    assign seq_p0 = (state != ST_IDLE);
    assign rd_p0  = (state == ST_IDLE) && !csb0 &&  web0;
    assign wr_p0  = (state == ST_IDLE) && !csb0 && !web0 && (|wmask0);

    // ---- stage p0 -> array: storage write port -----------------------------
    // Storage is deliberately not reset; the init sequencer rewrites it.
    always_ff @(posedge clk0) begin
        if (seq_p0) begin
            mem[ptr] <= INIT_VALUE;
        end else if (wr_p0) begin
            mem[addr0] <= merge_word(mem[addr0], din0, wmask0);
        end
    end

    // ---- stage p0 -> p1: sequencer FSM and registered outputs --------------
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_INIT;
            ptr    <= '0;
            ready0 <= 1'b0;
            dout0  <= '0;
        end else begin
            case (state)
                ST_INIT, ST_FLUSH: begin
                    // ptr wraps to 0 naturally on the last entry.
                    ptr <= ptr + ADDR_WIDTH'(1);
                    if (ptr == LAST_PTR) begin
                        state  <= ST_IDLE;
                        ready0 <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (rd_p0) begin
                        dout0 <= mem[addr0];
                    end
                    // The access on this same edge still completes above.
                    if (flush0) begin
                        state  <= ST_FLUSH;
                        ptr    <= '0;
                        ready0 <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_INIT;
                    ptr    <= '0;
                    ready0 <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_sram_array.sv
module tb_cache_sram_array;

    logic        clk = 1'b0;

    // Instance A: default parameters (24 bit, 16 deep, 3 groups, init 0)
    logic        rst_n  = 1'b1;
    logic        csb0   = 1'b1;
    logic        web0   = 1'b1;
    logic [2:0]  wmask0 = 3'b000;
    logic [3:0]  addr0  = '0;
    logic [23:0] din0   = '0;
    logic        flush0 = 1'b0;
    logic [23:0] dout0;
    logic        ready0;

    // Instance B: 32 bit, 64 deep, 4 groups, init 0xDEADBEEF
    logic        rst_n_b = 1'b1;
    logic        csb_b   = 1'b1;
    logic        web_b   = 1'b1;
    logic [3:0]  wmask_b = 4'b0000;
    logic [5:0]  addr_b  = '0;
    logic [31:0] din_b   = '0;
    logic        flush_b = 1'b0;
    logic [31:0] dout_b;
    logic        ready_b;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    cache_sram_array u_dut (
        .clk0   (clk),
        .rst_n  (rst_n),
        .csb0   (csb0),
        .web0   (web0),
        .wmask0 (wmask0),
        .addr0  (addr0),
        .din0   (din0),
        .flush0 (flush0),
        .dout0  (dout0),
        .ready0 (ready0)
    );

    cache_sram_array #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (6),
        .WMASK_WIDTH (4),
        .INIT_VALUE  (32'hDEADBEEF)
    ) u_dut_b (
        .clk0   (clk),
        .rst_n  (rst_n_b),
        .csb0   (csb_b),
        .web0   (web_b),
        .wmask0 (wmask_b),
        .addr0  (addr_b),
        .din0   (din_b),
        .flush0 (flush_b),
        .dout0  (dout_b),
        .ready0 (ready_b)
    );

    function automatic logic [23:0] fill_val(input int a);
        return 24'h100000 + 24'(a) * 24'h010101;
    endfunction

    // All access tasks are entered at a negedge and return at the next one,
    // so outputs produced by the intervening posedge are visible on return.
    task automatic wr_a(input logic [3:0] a, input logic [23:0] d, input logic [2:0] m);
        csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m;
        @(negedge clk);
        csb0 = 1'b1; web0 = 1'b1; wmask0 = 3'b000;
    endtask

    task automatic rd_a(input logic [3:0] a);
        csb0 = 1'b0; web0 = 1'b1; addr0 = a;
        @(negedge clk);
        csb0 = 1'b1;
    endtask

    task automatic wr_b(input logic [5:0] a, input logic [31:0] d, input logic [3:0] m);
        csb_b = 1'b0; web_b = 1'b0; addr_b = a; din_b = d; wmask_b = m;
        @(negedge clk);
        csb_b = 1'b1; web_b = 1'b1; wmask_b = 4'b0000;
    endtask

    task automatic rd_b(input logic [5:0] a);
        csb_b = 1'b0; web_b = 1'b1; addr_b = a;
        @(negedge clk);
        csb_b = 1'b1;
    endtask

    // Release reset of instance A at a negedge and count posedges until ready0.
    task automatic count_ready_a(input string name);
        int edges;
        edges = 0;
        @(negedge clk);
        rst_n = 1'b1;
        while (edges < 200) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (ready0 === 1'b1) break;
        end
        vectors++;
        if (edges !== 16) begin
            errors++;
            $display("FAIL %s: ready0 rose after %0d edges, required 16", name, edges);
        end
    endtask

    task automatic check_all_zero_a(input string name);
        for (int a = 0; a < 16; a++) begin
            rd_a(4'(a));
            vectors++;
            if (dout0 !== 24'h000000) begin
                errors++;
                $display("FAIL %s addr %0d: dout0=%h required 000000", name, a, dout0);
            end
        end
    endtask

    task automatic test_reset;
        #1 rst_n = 1'b0; rst_n_b = 1'b0;
        #1;
        vectors++;
        if (dout0 !== 24'h000000 || ready0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: dout0=%h ready0=%b required 000000/0", dout0, ready0);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (dout0 !== 24'h000000 || ready0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: dout0=%h ready0=%b required 000000/0", dout0, ready0);
        end
        count_ready_a("init_edges");
        check_all_zero_a("init_read");
    endtask

    task automatic test_masked_write;
        wr_a(4'd5, 24'hABCDEF, 3'b111);
        wr_a(4'd5, 24'h123456, 3'b010);
        rd_a(4'd5);
        vectors++;
        if (dout0 !== 24'hAB34EF) begin
            errors++;
            $display("FAIL masked_write: dout0=%h required AB34EF", dout0);
        end
        // A write must leave dout0 untouched.
        wr_a(4'd5, 24'h999999, 3'b000);
        vectors++;
        if (dout0 !== 24'hAB34EF) begin
            errors++;
            $display("FAIL write_holds_dout: dout0=%h required AB34EF", dout0);
        end
        rd_a(4'd5);
        vectors++;
        if (dout0 !== 24'hAB34EF) begin
            errors++;
            $display("FAIL zero_mask_write: dout0=%h required AB34EF", dout0);
        end
    endtask

    task automatic test_back_to_back;
        wr_a(4'd15, 24'h00FF00, 3'b111);
        rd_a(4'd15);
        vectors++;
        if (dout0 !== 24'h00FF00) begin
            errors++;
            $display("FAIL write_then_read: dout0=%h required 00FF00", dout0);
        end
        rd_a(4'd5);
        // Two reads on consecutive edges with no idle cycle between them.
        csb0 = 1'b0; web0 = 1'b1; addr0 = 4'd0;
        @(negedge clk);
        addr0 = 4'd15;
        vectors++;
        if (dout0 !== 24'h000000) begin
            errors++;
            $display("FAIL b2b_read0: dout0=%h required 000000", dout0);
        end
        @(negedge clk);
        csb0 = 1'b1;
        vectors++;
        if (dout0 !== 24'h00FF00) begin
            errors++;
            $display("FAIL b2b_read15: dout0=%h required 00FF00", dout0);
        end
        // Deselected cycle: dout0 holds.
        @(negedge clk);
        vectors++;
        if (dout0 !== 24'h00FF00) begin
            errors++;
            $display("FAIL deselect_hold: dout0=%h required 00FF00", dout0);
        end
    endtask

    task automatic test_flush;
        int low;
        for (int a = 0; a < 16; a++) wr_a(4'(a), fill_val(a), 3'b111);
        for (int a = 0; a < 16; a++) begin
            rd_a(4'(a));
            vectors++;
            if (dout0 !== fill_val(a)) begin
                errors++;
                $display("FAIL fill addr %0d: dout0=%h required %h", a, dout0, fill_val(a));
            end
        end
        rd_a(4'd7);
        // Flush request together with a write; the write still happens.
        flush0 = 1'b1; csb0 = 1'b0; web0 = 1'b0; addr0 = 4'd3;
        din0 = 24'h111111; wmask0 = 3'b111;
        @(negedge clk);
        flush0 = 1'b0; csb0 = 1'b1; web0 = 1'b1; wmask0 = 3'b000;
        low = 0;
        while (low < 100) begin
            if (ready0 === 1'b1) break;
            low++;
            // Accesses during the flush: writes to addr 0 (already cleared
            // after the first flush edge) alternate with reads of addr 9.
            csb0 = 1'b0;
            if (low[0]) begin
                web0 = 1'b0; addr0 = 4'd0; din0 = 24'hFFFFFF; wmask0 = 3'b111;
            end else begin
                web0 = 1'b1; addr0 = 4'd9; wmask0 = 3'b000;
            end
            @(negedge clk);
            csb0 = 1'b1; web0 = 1'b1; wmask0 = 3'b000;
        end
        vectors++;
        if (low !== 16) begin
            errors++;
            $display("FAIL flush_low_cycles: ready0 low for %0d cycles, required 16", low);
        end
        vectors++;
        if (dout0 !== fill_val(7)) begin
            errors++;
            $display("FAIL flush_dout_hold: dout0=%h required %h", dout0, fill_val(7));
        end
        check_all_zero_a("flush_read");
    endtask

    task automatic test_reset_mid_flush;
        wr_a(4'd12, 24'h777777, 3'b111);
        wr_a(4'd4, 24'h5A5A5A, 3'b111);
        rd_a(4'd4);
        vectors++;
        if (dout0 !== 24'h5A5A5A) begin
            errors++;
            $display("FAIL pre_flush_read: dout0=%h required 5A5A5A", dout0);
        end
        flush0 = 1'b1;
        @(negedge clk);
        flush0 = 1'b0;
        repeat (7) @(posedge clk);
        // ptr is now 7; assert reset between clock edges.
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (dout0 !== 24'h000000 || ready0 !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: dout0=%h ready0=%b required 000000/0", dout0, ready0);
        end
        @(negedge clk);
        count_ready_a("reinit_edges");
        check_all_zero_a("reinit_read");
    endtask

    task automatic test_param_sweep;
        int edges;
        edges = 0;
        @(negedge clk);
        rst_n_b = 1'b1;
        while (edges < 400) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (ready_b === 1'b1) break;
        end
        vectors++;
        if (edges !== 64) begin
            errors++;
            $display("FAIL sweep_init_edges: ready rose after %0d edges, required 64", edges);
        end
        for (int a = 0; a < 64; a++) begin
            rd_b(6'(a));
            vectors++;
            if (dout_b !== 32'hDEADBEEF) begin
                errors++;
                $display("FAIL sweep_init addr %0d: dout=%h required DEADBEEF", a, dout_b);
            end
        end
        wr_b(6'd63, 32'h12345678, 4'b0001);
        rd_b(6'd63);
        vectors++;
        if (dout_b !== 32'hDEADBE78) begin
            errors++;
            $display("FAIL sweep_masked: dout=%h required DEADBE78", dout_b);
        end
    endtask

    initial begin
        test_reset;
        test_masked_write;
        test_back_to_back;
        test_flush;
        test_reset_mid_flush;
        test_param_sweep;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/cache_sram_array.md
# cache_sram_array

Parametrised single-port (1RW) synchronous SRAM model for cache tag and data arrays. It adds three things to the plain OpenRAM array model: per-group write masking, a hardware init sequencer that clears every entry after reset, and a flush sequencer the cache controller can trigger at run time. It sits under the L1 cache controllers in place of the fixed 16x24 tag array, and one instance serves any width and depth.

## Interface
- DATA_WIDTH, 24, bits per word; must be a multiple of WMASK_WIDTH
- ADDR_WIDTH, 4, address bits; DEPTH = 1 << ADDR_WIDTH
- WMASK_WIDTH, 3, write-mask groups; each group covers DATA_WIDTH/WMASK_WIDTH bits
- INIT_VALUE, 0, word written to every entry by init and flush
- clk0  in  1  clock; all state changes on posedge
- rst_n  in  1  asynchronous active-low reset
- csb0  in  1  active-low chip select
- web0  in  1  active-low write enable
- wmask0  in  WMASK_WIDTH  per-group write enable; bit g covers din0[(g+1)*G-1 : g*G]
- addr0  in  ADDR_WIDTH  word address
- din0  in  DATA_WIDTH  write data
- flush0  in  1  flush request; level-sampled, only honoured in IDLE
- dout0  out  DATA_WIDTH  registered read data
- ready0  out  1  high when the array accepts accesses

## Operation
- The FSM has three states: INIT, IDLE and FLUSH. The sequencer counter `ptr` is ADDR_WIDTH bits wide.
- **Reset** (rst_n=0, asynchronous): state=INIT, ptr=0, ready0=0, dout0=0. Memory contents are not reset.
- **INIT / FLUSH**:
  - Each posedge writes INIT_VALUE to mem[ptr] and increments ptr.
  - The edge that writes ptr=DEPTH-1 wraps ptr to 0, moves to IDLE and sets ready0=1.
  - csb0, web0 and flush0 are ignored in these states. dout0 holds its value.
- **IDLE**:
  - Read (csb0=0, web0=1): dout0 <= mem[addr0] at that posedge.
  - Write (csb0=0, web0=0): each group with wmask0[g]=1 takes din0's group; groups with wmask0[g]=0 keep their old value. dout0 holds.
  - If wmask0 is all zero, nothing is written.
  - csb0=1: no access; dout0 holds.
- **flush0=1 in IDLE**: the access presented on the same edge completes normally. On that edge the state becomes FLUSH, ptr=0 and ready0=0.
- **Reset mid-INIT or mid-FLUSH**: the sequencer restarts at INIT with ptr=0. Partially cleared contents are irrelevant because every entry is rewritten.
- Width rule: INIT_VALUE is truncated or zero-extended to DATA_WIDTH.

## Timing
- Read latency is 1 cycle. Address is sampled at posedge N; dout0 is valid after posedge N and stable through posedge N+1.
- Write-then-read: a write at edge N followed by a read of the same address at edge N+1 returns the new data after edge N+1. No bypass is needed.
- A same-edge read and write cannot occur (single port).
- ready0 is registered.
  - It rises after exactly DEPTH posedges following rst_n deassertion.
  - It falls after the posedge that samples flush0=1 in IDLE.
  - It stays low for exactly DEPTH cycles.
- Accesses may be presented only while ready0=1. Requests made while ready0=0 are dropped, with no queueing.
- dout0 never goes X. It holds its last value whenever no read is performed.

## Test plan
- **Reset/init**: release rst_n, count edges.
  - ready0 rises after 16 edges (default params).
  - Reads of addresses 0..15 all return 0.
  - dout0=0 during reset.
- **Masked write**:
  - Write 0xABCDEF to addr 5 with wmask0=3'b111, then write 0x123456 with wmask0=3'b010.
  - A read of addr 5 returns 0xAB34EF.
  - A write with wmask0=3'b000 leaves the word unchanged.
- **Back-to-back**: write 0x00FF00 to addr 15, read addr 15 on the next edge -> dout0=0x00FF00 after that edge. Also read addr 0 then addr 15 on consecutive edges -> each value appears one edge after its address.
- **Flush**:
  - Fill all entries with nonzero data, then assert flush0 together with a write of 0x111111 to addr 3.
  - The write completes.
  - ready0=0 for 16 cycles.
  - Afterwards every address reads 0.
  - Accesses issued during the flush have no effect.
- **Reset mid-flush**:
  - Pulse rst_n low at ptr=7 of a flush.
  - ready0 stays low for a fresh 16 edges after release.
  - All entries read 0.
  - dout0 is 0 immediately on reset assertion, with no clock needed.
- **Parameter sweep**: DATA_WIDTH=32, ADDR_WIDTH=6, WMASK_WIDTH=4, INIT_VALUE=32'hDEADBEEF.
  - Init takes 64 edges.
  - Every address reads 0xDEADBEEF.
  - A write of 0x12345678 with wmask0=4'b0001 to addr 63 reads back 0xDEADBE78.
